// File: rtl/sdram_write_burst_if.sv
// Bus between the write engine, its arbiter/FIFO side and the SDRAM pins.
// The slave modport is the engine; the master modport is the surrounding logic.
interface sdram_write_burst_if #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 12,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2,
    parameter int LEN_W  = 8
);
    logic              wr_trig;
    logic [BANK_W-1:0] wr_bank;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [LEN_W-1:0]  wr_len;
    logic              ref_req;
    logic              wr_en;
    logic              flag_wr_ask;
    logic              flag_wr_end;
    logic              wr_done;
    logic              wr_busy;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_en;
    logic [3:0]        sdram_cmd;
    logic [BANK_W-1:0] sdram_ba;
    logic [ROW_W-1:0]  sdram_addr;
    logic [DATA_W-1:0] sdram_dq;
    logic              sdram_dq_oe;

    modport slave (
        input  wr_trig, wr_bank, wr_row, wr_col, wr_len, ref_req, wr_en, wr_data,
        output flag_wr_ask, flag_wr_end, wr_done, wr_busy, wr_data_en,
               sdram_cmd, sdram_ba, sdram_addr, sdram_dq, sdram_dq_oe
    );

    modport master (
        output wr_trig, wr_bank, wr_row, wr_col, wr_len, ref_req, wr_en, wr_data,
        input  flag_wr_ask, flag_wr_end, wr_done, wr_busy, wr_data_en,
               sdram_cmd, sdram_ba, sdram_addr, sdram_dq, sdram_dq_oe
    );
endinterface

// File: rtl/sdram_write_burst.sv
// SDRAM multi-burst write engine: ACT, back-to-back WRITEs, PRE, with automatic
// row crossing and yielding to refresh at burst boundaries.
module sdram_write_burst #(
    parameter int DATA_W = 16,
    parameter int ROW_W  = 12,
    parameter int COL_W  = 9,
    parameter int BANK_W = 2,
    parameter int BURST  = 4,
    parameter int LEN_W  = 8,
    parameter int T_RCD  = 2,
    parameter int T_WR   = 2,
    parameter int T_RP   = 2
) (
    input  logic               sclk,
    input  logic               srst,
    sdram_write_burst_if.slave bus
);
    localparam int LB     = $clog2(BURST);
    localparam int WAIT_W = 8;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;

    localparam logic [LB-1:0] BEAT_LAST   = LB'(BURST - 1);
    localparam logic [LB-1:0] BEAT_DECIDE = LB'(BURST - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_REQ, S_ACT, S_WAIT_RCD, S_WRITE, S_WAIT_WR, S_PRE, S_WAIT_RP, S_END
    } state_t;

    state_t            state_q, state_d;
    logic [LB-1:0]     beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              cont_q, cont_d;
    logic              reopen_q, reopen_d;

    logic              ask_q, ask_d;
    logic              end_q, end_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              den_q, den_d;
    logic              oe_q, oe_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BANK_W-1:0] ba_q, ba_d;
    logic [ROW_W-1:0]  addr_q, addr_d;

    logic              issue;
    logic [COL_W:0]    col_sum;

    assign col_sum = {1'b0, col_q} + (COL_W + 1)'(BURST);

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        wait_d   = wait_q;
        bank_d   = bank_q;
        row_d    = row_q;
        col_d    = col_q;
        len_d    = len_q;
        cont_d   = cont_q;
        reopen_d = reopen_q;
        issue    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.wr_trig && (bus.wr_len != '0)) begin
                    state_d = S_REQ;
                    bank_d  = bus.wr_bank;
                    row_d   = bus.wr_row;
                    col_d   = bus.wr_col & ~COL_W'(BURST - 1);
                    len_d   = bus.wr_len;
                end
            end
            S_REQ: begin
                if (bus.wr_en) state_d = S_ACT;
            end
            S_ACT: begin
                if (T_RCD > 1) begin
                    state_d = S_WAIT_RCD;
                    wait_d  = WAIT_W'(T_RCD - 2);
                end else begin
                    state_d = S_WRITE;
                    beat_d  = '0;
                end
            end
            S_WAIT_RCD: begin
                if (wait_q == '0) begin
                    state_d = S_WRITE;
                    beat_d  = '0;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_WRITE: begin
                beat_d = beat_q + 1'b1;
                // Burst-boundary decision is taken one beat early so that the
                // registered data pop strobe can already cover the next burst.
                if (beat_q == BEAT_DECIDE) begin
                    cont_d   = (len_q != '0) && !bus.ref_req && (col_q != '0);
                    reopen_d = (len_q != '0) && !bus.ref_req && (col_q == '0);
                end
                if ((beat_q == BEAT_LAST) && !cont_q) begin
                    if (T_WR > 1) begin
                        state_d = S_WAIT_WR;
                        wait_d  = WAIT_W'(T_WR - 2);
                    end else begin
                        state_d = S_PRE;
                    end
                end
            end
            S_WAIT_WR: begin
                if (wait_q == '0) state_d = S_PRE;
                else              wait_d  = wait_q - 1'b1;
            end
            S_PRE: begin
                if (T_RP > 1) begin
                    state_d = S_WAIT_RP;
                    wait_d  = WAIT_W'(T_RP - 2);
                end else begin
                    state_d = reopen_q ? S_ACT : S_END;
                end
            end
            S_WAIT_RP: begin
                if (wait_q == '0) state_d = reopen_q ? S_ACT : S_END;
                else              wait_d  = wait_q - 1'b1;
            end
            S_END: begin
                state_d = (len_q == '0) ? S_IDLE : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        // Address and length advance on the edge that loads each WRITE command.
        issue = (state_d == S_WRITE) && (beat_d == '0);
        if (issue) begin
            col_d = col_sum[COL_W-1:0];
            if (col_sum[COL_W]) row_d = row_q + 1'b1;
            len_d = len_q - 1'b1;
        end

        ask_d  = (state_d == S_REQ);
        end_d  = (state_d == S_END);
        done_d = (state_d == S_END) && (len_d == '0);
        busy_d = (state_d != S_IDLE);
        oe_d   = (state_d == S_WRITE);

        cmd_d  = CMD_NOP;
        ba_d   = '0;
        addr_d = '0;
        case (state_d)
            S_ACT: begin
                cmd_d  = CMD_ACT;
                ba_d   = bank_q;
                addr_d = row_q;
            end
            S_PRE: begin
                cmd_d = CMD_PRE;
                ba_d  = bank_q;
            end
            S_WRITE: begin
                if (issue) begin
                    cmd_d  = CMD_WRITE;
                    ba_d   = bank_q;
                    addr_d = ROW_W'(col_q);
                end
            end
            default: cmd_d = CMD_NOP;
        endcase

        den_d = 1'b0;
        if (state_d == S_WRITE)
            den_d = (beat_d != BEAT_LAST) || cont_d;
        else if ((state_d == S_WAIT_RCD) && (wait_d == '0))
            den_d = 1'b1;
        else if ((state_d == S_ACT) && (T_RCD == 1))
            den_d = 1'b1;
    end

    always_ff @(posedge sclk) begin
        if (srst) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            wait_q   <= '0;
            bank_q   <= '0;
            row_q    <= '0;
            col_q    <= '0;
            len_q    <= '0;
            cont_q   <= 1'b0;
            reopen_q <= 1'b0;
            ask_q    <= 1'b0;
            end_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            den_q    <= 1'b0;
            oe_q     <= 1'b0;
            cmd_q    <= CMD_NOP;
            ba_q     <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wait_q   <= wait_d;
            bank_q   <= bank_d;
            row_q    <= row_d;
            col_q    <= col_d;
            len_q    <= len_d;
            cont_q   <= cont_d;
            reopen_q <= reopen_d;
            ask_q    <= ask_d;
            end_q    <= end_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            den_q    <= den_d;
            oe_q     <= oe_d;
            cmd_q    <= cmd_d;
            ba_q     <= ba_d;
            addr_q   <= addr_d;
        end
    end

    assign bus.flag_wr_ask = ask_q;
    assign bus.flag_wr_end = end_q;
    assign bus.wr_done     = done_q;
    assign bus.wr_busy     = busy_q;
    assign bus.wr_data_en  = den_q;
    assign bus.sdram_cmd   = cmd_q;
    assign bus.sdram_ba    = ba_q;
    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_dq_oe = oe_q;
    // The FIFO's registered read port already holds each beat in its beat cycle.
    assign bus.sdram_dq    = oe_q ? bus.wr_data : {DATA_W{1'b0}};
endmodule

// File: tb/tb_sdram_write_burst.sv
// Directed bench for sdram_write_burst: logs pin activity per cycle, then each
// scenario task compares the log against hand-derived cycle numbers and values.
`timescale 1ns/1ps
module tb_sdram_write_burst;
    logic sclk = 1'b0;
    logic srst = 1'b1;
    always #5 sclk = ~sclk;

    sdram_write_burst_if bus ();
    sdram_write_burst dut (.sclk(sclk), .srst(srst), .bus(bus));

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge sclk) cyc <= cyc + 1;

    logic [15:0] fifo_q = 16'h1000;
    int          pops   = 0;
    always @(posedge sclk) begin
        if (bus.wr_data_en) begin
            pops   <= pops + 1;
            fifo_q <= 16'h1000 + 16'(pops + 1);
        end
    end
    assign bus.wr_data = fifo_q;

    int          act_cyc[$], wr_cyc[$], pre_cyc[$], oe_cyc[$];
    int          den_cyc[$], end_cyc[$], done_cyc[$], ask_cyc[$];
    logic [11:0] act_addr[$], wr_addr[$], pre_addr[$];
    logic [1:0]  act_ba[$];
    logic [15:0] dq_val[$];

    always @(negedge sclk) begin
        case (bus.sdram_cmd)
            4'b0011: begin act_cyc.push_back(cyc); act_addr.push_back(bus.sdram_addr); act_ba.push_back(bus.sdram_ba); end
            4'b0100: begin wr_cyc.push_back(cyc); wr_addr.push_back(bus.sdram_addr); end
            4'b0010: begin pre_cyc.push_back(cyc); pre_addr.push_back(bus.sdram_addr); end
            default: ;
        endcase
        if (bus.sdram_dq_oe) begin oe_cyc.push_back(cyc); dq_val.push_back(bus.sdram_dq); end
        if (bus.wr_data_en)  den_cyc.push_back(cyc);
        if (bus.flag_wr_end) end_cyc.push_back(cyc);
        if (bus.wr_done)     done_cyc.push_back(cyc);
        if (bus.flag_wr_ask) ask_cyc.push_back(cyc);
    end

    task automatic step(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic clear_logs();
        act_cyc.delete(); wr_cyc.delete(); pre_cyc.delete(); oe_cyc.delete();
        den_cyc.delete(); end_cyc.delete(); done_cyc.delete(); ask_cyc.delete();
        act_addr.delete(); wr_addr.delete(); pre_addr.delete(); act_ba.delete(); dq_val.delete();
    endtask

    task automatic trigger(input logic [1:0] b, input logic [11:0] r, input logic [8:0] c, input logic [7:0] l);
        $display("xfer cyc=%0d bank=%0d row=%0d col=%0d len=%0d", cyc, b, r, c, l);
        bus.wr_bank = b; bus.wr_row = r; bus.wr_col = c; bus.wr_len = l;
        bus.wr_trig = 1'b1;
        step(1);
        bus.wr_trig = 1'b0;
    endtask

    task automatic grant(output int g);
        bus.wr_en = 1'b1;
        g = cyc;
        step(1);
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.wr_busy && n < 300) begin step(1); n++; end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        step(3);
        total++;
        if ({bus.flag_wr_ask, bus.flag_wr_end, bus.wr_done, bus.wr_busy, bus.wr_data_en, bus.sdram_dq_oe, bus.sdram_cmd} !== 10'b000000_0111) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000000111", {bus.flag_wr_ask, bus.flag_wr_end, bus.wr_done, bus.wr_busy, bus.wr_data_en, bus.sdram_dq_oe, bus.sdram_cmd});
        end
        total++;
        if ({bus.sdram_ba, bus.sdram_addr, bus.sdram_dq} !== 30'd0) begin
            bad++; $display("FAIL reset_bus got ba=%0d addr=%0d dq=%h exp all 0", bus.sdram_ba, bus.sdram_addr, bus.sdram_dq);
        end
        srst = 1'b0;
        step(1);
    endtask

    task automatic test_single();
        int g, n, p0, errs;
        clear_logs();
        p0 = pops;
        trigger(2'd1, 12'd5, 9'd0, 8'd1);
        step(2);
        grant(g);
        wait_idle(n);
        total++; if (bus.wr_busy !== 1'b0) begin bad++; $display("FAIL single_timeout busy=%b exp=0", bus.wr_busy); end
        total++; if (ask_cyc.size() != 3 || ask_cyc[2] != g) begin bad++; $display("FAIL single_ask got n=%0d last=%0d exp n=3 last=%0d", ask_cyc.size(), ask_cyc[2], g); end
        total++; if (act_cyc.size() != 1 || act_cyc[0] != g + 1 || act_addr[0] !== 12'd5 || act_ba[0] !== 2'd1) begin
            bad++; $display("FAIL single_act got n=%0d cyc=%0d addr=%0d ba=%0d exp n=1 cyc=%0d addr=5 ba=1", act_cyc.size(), act_cyc[0], act_addr[0], act_ba[0], g + 1); end
        total++; if (wr_cyc.size() != 1 || wr_cyc[0] != g + 3 || wr_addr[0] !== 12'd0) begin
            bad++; $display("FAIL single_write got n=%0d cyc=%0d addr=%0d exp n=1 cyc=%0d addr=0", wr_cyc.size(), wr_cyc[0], wr_addr[0], g + 3); end
        errs = 0;
        for (int k = 0; k < 4; k++) if (dq_val[k] !== 16'h1000 + 16'(p0 + 1 + k) || oe_cyc[k] != g + 3 + k) errs++;
        total++; if (oe_cyc.size() != 4 || errs != 0) begin bad++; $display("FAIL single_beats got n=%0d errs=%0d first=%h exp n=4 errs=0 first=%h", oe_cyc.size(), errs, dq_val[0], 16'h1000 + 16'(p0 + 1)); end
        total++; if (den_cyc.size() != 4 || den_cyc[0] != g + 2 || den_cyc[3] != g + 5) begin
            bad++; $display("FAIL single_den got n=%0d first=%0d last=%0d exp n=4 first=%0d last=%0d", den_cyc.size(), den_cyc[0], den_cyc[3], g + 2, g + 5); end
        total++; if (pre_cyc.size() != 1 || pre_cyc[0] != g + 8 || pre_addr[0][10] !== 1'b0) begin
            bad++; $display("FAIL single_pre got n=%0d cyc=%0d a10=%b exp n=1 cyc=%0d a10=0", pre_cyc.size(), pre_cyc[0], pre_addr[0][10], g + 8); end
        total++; if (end_cyc.size() != 1 || end_cyc[0] != g + 10 || done_cyc.size() != 1 || done_cyc[0] != g + 10) begin
            bad++; $display("FAIL single_end got end n=%0d cyc=%0d done n=%0d cyc=%0d exp 1 at %0d", end_cyc.size(), end_cyc[0], done_cyc.size(), done_cyc[0], g + 10); end
    endtask

    task automatic test_back_to_back();
        int g, n, p0, errs;
        clear_logs();
        p0 = pops;
        trigger(2'd0, 12'd2, 9'd0, 8'd3);
        grant(g);
        wait_idle(n);
        total++; if (bus.wr_busy !== 1'b0) begin bad++; $display("FAIL b2b_timeout busy=%b exp=0", bus.wr_busy); end
        total++; if (wr_cyc.size() != 3 || wr_addr[0] !== 12'd0 || wr_addr[1] !== 12'd4 || wr_addr[2] !== 12'd8) begin
            bad++; $display("FAIL b2b_cols got n=%0d cols=%0d,%0d,%0d exp n=3 cols=0,4,8", wr_cyc.size(), wr_addr[0], wr_addr[1], wr_addr[2]); end
        total++; if (wr_cyc[0] != g + 3 || wr_cyc[1] != g + 7 || wr_cyc[2] != g + 11) begin
            bad++; $display("FAIL b2b_spacing got %0d,%0d,%0d exp %0d,%0d,%0d", wr_cyc[0], wr_cyc[1], wr_cyc[2], g + 3, g + 7, g + 11); end
        total++; if (den_cyc.size() != 12 || den_cyc[11] - den_cyc[0] != 11) begin
            bad++; $display("FAIL b2b_den got n=%0d span=%0d exp n=12 span=11", den_cyc.size(), den_cyc[11] - den_cyc[0]); end
        total++; if (act_cyc.size() != 1 || pre_cyc.size() != 1 || pre_cyc[0] != g + 16) begin
            bad++; $display("FAIL b2b_actpre got act=%0d pre=%0d precyc=%0d exp act=1 pre=1 precyc=%0d", act_cyc.size(), pre_cyc.size(), pre_cyc[0], g + 16); end
        errs = 0;
        for (int k = 0; k < 12; k++) if (dq_val[k] !== 16'h1000 + 16'(p0 + 1 + k)) errs++;
        total++; if (oe_cyc.size() != 12 || errs != 0) begin bad++; $display("FAIL b2b_data got n=%0d errs=%0d exp n=12 errs=0", oe_cyc.size(), errs); end
        total++; if (done_cyc.size() != 1 || done_cyc[0] != g + 18) begin bad++; $display("FAIL b2b_done got n=%0d cyc=%0d exp n=1 cyc=%0d", done_cyc.size(), done_cyc[0], g + 18); end
    endtask

    task automatic test_row_cross(input logic [11:0] row, input logic [11:0] next_row);
        int g, n;
        clear_logs();
        trigger(2'd2, row, 9'd508, 8'd2);
        grant(g);
        ask_cyc.delete();
        wait_idle(n);
        total++; if (bus.wr_busy !== 1'b0) begin bad++; $display("FAIL rowx_timeout busy=%b exp=0", bus.wr_busy); end
        total++; if (act_cyc.size() != 2 || act_addr[0] !== row || act_addr[1] !== next_row || act_ba[1] !== 2'd2) begin
            bad++; $display("FAIL rowx_act got n=%0d rows=%0d,%0d ba=%0d exp n=2 rows=%0d,%0d ba=2", act_cyc.size(), act_addr[0], act_addr[1], act_ba[1], row, next_row); end
        total++; if (wr_cyc.size() != 2 || wr_addr[0] !== 12'd508 || wr_addr[1] !== 12'd0) begin
            bad++; $display("FAIL rowx_cols got n=%0d cols=%0d,%0d exp n=2 cols=508,0", wr_cyc.size(), wr_addr[0], wr_addr[1]); end
        total++; if (pre_cyc.size() != 2 || pre_cyc[0] != wr_cyc[0] + 5 || act_cyc[1] != pre_cyc[0] + 2 || wr_cyc[1] != act_cyc[1] + 2) begin
            bad++; $display("FAIL rowx_seq got wr0=%0d pre0=%0d act1=%0d wr1=%0d exp pre0=wr0+5 act1=pre0+2 wr1=act1+2", wr_cyc[0], pre_cyc[0], act_cyc[1], wr_cyc[1]); end
        total++; if (ask_cyc.size() != 0 || end_cyc.size() != 1 || done_cyc.size() != 1) begin
            bad++; $display("FAIL rowx_flags got ask=%0d end=%0d done=%0d exp ask=0 end=1 done=1", ask_cyc.size(), end_cyc.size(), done_cyc.size()); end
    endtask

    task automatic test_refresh();
        int g, n;
        clear_logs();
        trigger(2'd3, 12'd9, 9'd0, 8'd4);
        grant(g);
        n = 0;
        while (wr_cyc.size() < 2 && n < 100) begin step(1); n++; end
        bus.ref_req = 1'b1;
        n = 0;
        while (pre_cyc.size() < 1 && n < 100) begin step(1); n++; end
        bus.ref_req = 1'b0;
        total++; if (wr_cyc.size() != 2 || pre_cyc.size() != 1 || pre_cyc[0] != wr_cyc[1] + 5) begin
            bad++; $display("FAIL ref_pre got writes=%0d pres=%0d precyc=%0d exp writes=2 pres=1 precyc=%0d", wr_cyc.size(), pre_cyc.size(), pre_cyc[0], wr_cyc[1] + 5); end
        n = 0;
        while (!bus.flag_wr_ask && n < 50) begin step(1); n++; end
        total++; if (bus.flag_wr_ask !== 1'b1 || end_cyc.size() != 1 || done_cyc.size() != 0 || bus.wr_busy !== 1'b1) begin
            bad++; $display("FAIL ref_yield got ask=%b end=%0d done=%0d busy=%b exp ask=1 end=1 done=0 busy=1", bus.flag_wr_ask, end_cyc.size(), done_cyc.size(), bus.wr_busy); end
        step(2);
        grant(g);
        wait_idle(n);
        total++; if (bus.wr_busy !== 1'b0) begin bad++; $display("FAIL ref_timeout busy=%b exp=0", bus.wr_busy); end
        total++; if (act_cyc.size() != 2 || act_addr[1] !== 12'd9 || act_cyc[1] != g + 1) begin
            bad++; $display("FAIL ref_reopen got n=%0d row=%0d cyc=%0d exp n=2 row=9 cyc=%0d", act_cyc.size(), act_addr[1], act_cyc[1], g + 1); end
        total++; if (wr_cyc.size() != 4 || wr_addr[2] !== 12'd8 || wr_addr[3] !== 12'd12 || wr_cyc[3] - wr_cyc[2] != 4) begin
            bad++; $display("FAIL ref_resume got n=%0d cols=%0d,%0d gap=%0d exp n=4 cols=8,12 gap=4", wr_cyc.size(), wr_addr[2], wr_addr[3], wr_cyc[3] - wr_cyc[2]); end
        total++; if (end_cyc.size() != 2 || done_cyc.size() != 1) begin
            bad++; $display("FAIL ref_done got end=%0d done=%0d exp end=2 done=1", end_cyc.size(), done_cyc.size()); end
    endtask

    task automatic test_ignored();
        int g, n;
        clear_logs();
        trigger(2'd1, 12'd3, 9'd0, 8'd0);
        step(2);
        total++; if (bus.wr_busy !== 1'b0 || ask_cyc.size() != 0 || bus.sdram_cmd !== 4'b0111) begin
            bad++; $display("FAIL ign_len0 got busy=%b asks=%0d cmd=%b exp busy=0 asks=0 cmd=0111", bus.wr_busy, ask_cyc.size(), bus.sdram_cmd); end
        trigger(2'd1, 12'd20, 9'd6, 8'd1);
        grant(g);
        n = 0;
        while (wr_cyc.size() < 1 && n < 50) begin step(1); n++; end
        trigger(2'd3, 12'd100, 9'd0, 8'd5);
        wait_idle(n);
        step(3);
        total++; if (bus.wr_busy !== 1'b0 || act_cyc.size() != 1 || act_addr[0] !== 12'd20 || done_cyc.size() != 1) begin
            bad++; $display("FAIL ign_busy got busy=%b acts=%0d row=%0d done=%0d exp busy=0 acts=1 row=20 done=1", bus.wr_busy, act_cyc.size(), act_addr[0], done_cyc.size()); end
        total++; if (wr_cyc.size() != 1 || wr_addr[0] !== 12'd4) begin
            bad++; $display("FAIL ign_col6 got n=%0d col=%0d exp n=1 col=4", wr_cyc.size(), wr_addr[0]); end
    endtask

    task automatic test_reset_mid();
        int g, n;
        clear_logs();
        trigger(2'd0, 12'd3, 9'd0, 8'd2);
        grant(g);
        n = 0;
        while (oe_cyc.size() < 2 && n < 50) begin step(1); n++; end
        total++; if (bus.sdram_dq_oe !== 1'b1 || cyc != g + 5) begin
            bad++; $display("FAIL rstmid_beat2 got oe=%b cyc=%0d exp oe=1 cyc=%0d", bus.sdram_dq_oe, cyc, g + 5); end
        srst = 1'b1;
        step(1);
        total++;
        if ({bus.sdram_cmd, bus.sdram_dq_oe, bus.wr_busy, bus.flag_wr_ask, bus.flag_wr_end, bus.wr_done, bus.wr_data_en} !== 10'b0111_000000) begin
            bad++; $display("FAIL rstmid_outs got=%b exp=0111000000", {bus.sdram_cmd, bus.sdram_dq_oe, bus.wr_busy, bus.flag_wr_ask, bus.flag_wr_end, bus.wr_done, bus.wr_data_en});
        end
        srst = 1'b0;
        clear_logs();
        step(10);
        total++; if (pre_cyc.size() != 0 || wr_cyc.size() != 0 || bus.wr_busy !== 1'b0) begin
            bad++; $display("FAIL rstmid_quiet got pres=%0d writes=%0d busy=%b exp 0 0 0", pre_cyc.size(), wr_cyc.size(), bus.wr_busy); end
    endtask

    initial begin
        bus.wr_trig = 1'b0; bus.wr_bank = '0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_len = '0; bus.ref_req = 1'b0; bus.wr_en = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_row_cross(12'd7, 12'd8);
        test_row_cross(12'd4095, 12'd0);
        test_refresh();
        test_ignored();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
